// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: binary edge map or saturated |Gx|+|Gy|.
// Latency: one cycle from the qualifying input transfer to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result freezes the pipeline.
// Ports: clk/reset (async, active low); in_valid/in_ready/in_data raster pixel stream;
//        mode/threshold sampled at row 0 col 0 of each frame; out_valid/out_ready/out_data/out_last
//        result stream, one result per interior pixel, out_last on the final one of a frame.
module sobel_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  input  logic             mode,
  input  logic [PIX_W+3:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = PIX_W + 4;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [SW-1:0] PIX_MAX  = {{(SW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  // Position counters, per-frame configuration and the output register.
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             mode_q, mode_d;
  logic [SW-1:0]    thr_q, thr_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  // Line buffers hold rows r-1 (lb1) and r-2 (lb2). The window keeps only the
  // two older columns; the newest column comes straight from the buffers and in_data.
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];
  logic [PIX_W-1:0] win_top_q [2];
  logic [PIX_W-1:0] win_mid_q [2];
  logic [PIX_W-1:0] win_bot_q [2];

  logic             xfer, emit, col_last, row_last;
  logic [PIX_W-1:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic [SW-1:0]    gx, gy, ax, ay, mag;
  logic [PIX_W-1:0] res;

  function automatic logic [SW-1:0] widen(input logic [PIX_W-1:0] v);
    return {{(SW-PIX_W){1'b0}}, v};
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    xfer     = in_valid && in_ready;
    col_last = (col_q == COL_LAST);
    row_last = (row_q == ROW_LAST);
    emit     = xfer && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    // Window as it will be after this transfer: p2/p5/p8 are the incoming column.
    p0 = win_top_q[0]; p1 = win_top_q[1]; p2 = lb2_q[col_q];
    p3 = win_mid_q[0];                    p5 = lb1_q[col_q];
    p6 = win_bot_q[0]; p7 = win_bot_q[1]; p8 = in_data;

    // Exact arithmetic in SW bits; magnitudes never exceed 2^(SW-1), so the MSB is the sign.
    gx  = (widen(p2) + (widen(p5) << 1) + widen(p8)) - (widen(p0) + (widen(p3) << 1) + widen(p6));
    gy  = (widen(p6) + (widen(p7) << 1) + widen(p8)) - (widen(p0) + (widen(p1) << 1) + widen(p2));
    ax  = gx[SW-1] ? (SW'(0) - gx) : gx;
    ay  = gy[SW-1] ? (SW'(0) - gy) : gy;
    mag = ax + ay;

    if (mode_q) begin
      res = (mag > PIX_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
    end else begin
      res = (mag > thr_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (xfer) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) begin
        row_d = row_last ? '0 : row_q + RW'(1);
      end
      // Configuration is frozen for the frame at its first pixel.
      if ((row_q == '0) && (col_q == '0)) begin
        mode_d = mode;
        thr_d  = threshold;
      end
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_last_d  = row_last && col_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 1'b0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Storage is refilled before any of it reaches an emitted result, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1_q[col_q] <= in_data;
      lb2_q[col_q] <= lb1_q[col_q];
      win_top_q[0] <= win_top_q[1];
      win_top_q[1] <= p2;
      win_mid_q[0] <= win_mid_q[1];
      win_mid_q[1] <= p5;
      win_bot_q[0] <= win_bot_q[1];
      win_bot_q[1] <= p8;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: reference Sobel model feeds a scoreboard queue at input acceptance.
// Outputs are popped and compared when transferred; stalled outputs must hold steady.
// Covers reset state, flat/step/ramp images, both modes, stalls, mid-frame reset, mode latching.
module tb_sobel_stream;
  localparam int W    = 64;
  localparam int H    = 64;
  localparam int PW   = 8;
  localparam int NRES = (W-2)*(H-2);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          mode;
  logic [PW+3:0] threshold;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic [8:0]    exp_q [$];
  int            res_cnt, tgt_cnt, tgt_val;
  bit            stall_en = 1'b0;
  bit            gaps_en  = 1'b0;
  logic          lat_mode;
  logic [PW+3:0] lat_thr;
  bit            prev_stall = 1'b0;
  logic [PW-1:0] prev_dat;
  logic          prev_last;

  // Image kinds: 0 flat 100, 1 step 0/255 at col 32, 2 ramp = col, 3 step 0/10 at col 32.
  function automatic int img(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return (c >= 32) ? 255 : 0;
      2:       return c;
      default: return (c >= 32) ? 10 : 0;
    endcase
  endfunction

  // Expected result for the input transfer at (r, c), i.e. centre (r-1, c-1).
  function automatic logic [7:0] sobel_ref(input int kind, input int r, input int c,
                                           input logic m, input logic [PW+3:0] thr);
    int p [0:2][0:2];
    int gx, gy, mag;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img(kind, r-2+i, c-2+j);
    gx  = p[0][2] + 2*p[1][2] + p[2][2] - p[0][0] - 2*p[1][0] - p[2][0];
    gy  = p[2][0] + 2*p[2][1] + p[2][2] - p[0][0] - 2*p[0][1] - p[0][2];
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m) return (mag > 255) ? 8'hFF : 8'(mag);
    return (mag > int'(thr)) ? 8'hFF : 8'h00;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk_eq("hold_vld",  int'(out_valid), 1);
        chk_eq("hold_dat",  int'(out_data),  int'(prev_dat));
        chk_eq("hold_last", int'(out_last),  int'(prev_last));
      end
      if (out_valid && out_ready) begin
        chk_eq("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_eq("out_dat",  int'(out_data), int'(e[7:0]));
          chk_eq("out_last", int'(out_last), int'(e[8]));
        end
        res_cnt++;
        if (int'(out_data) == tgt_val) tgt_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Entered and left one time unit after a rising edge.
  task automatic send_px(input int kind, input int r, input int c);
    int budget;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = 8'(img(kind, r, c));
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (r == 0 && c == 0) begin
          lat_mode = mode;
          lat_thr  = threshold;
        end
        if (r >= 2 && c >= 2)
          exp_q.push_back({(r == H-1 && c == W-1), sobel_ref(kind, r, c, lat_mode, lat_thr)});
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      budget++;
      if (budget > 1000) begin
        chk_eq("in_ready_timeout", budget, 0);
        break;
      end
    end
  endtask

  task automatic drive_frame(input int kind, input int npx, input int sw_at, input logic sw_mode);
    int idx = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (idx == npx) return;
        if (idx == sw_at) mode = sw_mode;
        send_px(kind, r, c);
        idx++;
      end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain_left", int'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input int kind, input logic m, input int thr,
                           input int tv, input int exp_tgt);
    res_cnt   = 0;
    tgt_cnt   = 0;
    tgt_val   = tv;
    mode      = m;
    threshold = 12'(thr);
    drive_frame(kind, W*H, -1, 1'b0);
    drain();
    chk_eq({tag, "_nres"}, res_cnt, NRES);
    chk_eq({tag, "_tgt"},  tgt_cnt, exp_tgt);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    threshold = '0;
    lat_mode  = 1'b0;
    lat_thr   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_vld",  int'(out_valid), 0);
    chk_eq("rst_dat",  int'(out_data),  0);
    chk_eq("rst_last", int'(out_last),  0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk_eq("rdy_after_rst", int'(in_ready), 1);
    @(posedge clk);
    #1;

    run_frame("flat_m0",      0, 1'b0, 27, 0,   NRES);
    run_frame("step_m0",      1, 1'b0, 27, 255, 2*(H-2));
    run_frame("step_m1",      1, 1'b1, 27, 255, 2*(H-2));
    run_frame("ramp_m1",      2, 1'b1, 0,  8,   NRES);
    run_frame("ramp_m0_thr8", 2, 1'b0, 8,  0,   NRES);
    run_frame("ramp_m0_thr7", 2, 1'b0, 7,  255, NRES);

    stall_en = 1'b1;
    gaps_en  = 1'b1;
    run_frame("step_stall",   1, 1'b0, 27, 255, 2*(H-2));
    stall_en = 1'b0;
    gaps_en  = 1'b0;

    // Partial frame, then reset mid-frame and a fresh frame.
    mode      = 1'b0;
    threshold = 12'd27;
    drive_frame(0, 1000, -1, 1'b0);
    drain();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_eq("midrst_vld", int'(out_valid), 0);
    end
    chk_eq("midrst_dat",  int'(out_data), 0);
    chk_eq("midrst_last", int'(out_last), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk_eq("rdy_after_midrst", int'(in_ready), 1);
    @(posedge clk);
    #1;
    run_frame("flat_after_rst", 0, 1'b0, 27, 0, NRES);

    // Mode flips mid-frame; two frames back to back with no bubble.
    res_cnt   = 0;
    tgt_cnt   = 0;
    tgt_val   = 255;
    mode      = 1'b0;
    threshold = 12'd27;
    drive_frame(3, W*H, 2000, 1'b1);
    drive_frame(3, W*H, -1, 1'b1);
    drain();
    chk_eq("modesw_nres", res_cnt, 2*NRES);
    chk_eq("modesw_bin",  tgt_cnt, 2*(H-2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised Sobel edge detector for the image-processing path. It accepts a raster-order pixel stream with a valid/ready handshake and keeps two line buffers, so each input pixel is read once. It emits one result per interior pixel, either a binary edge map or a saturated gradient magnitude. It replaces the fixed 64x64, 10-cycles-per-pixel, ROM-addressed detector; upstream producers and downstream sinks connect through standard stream handshakes.

## Interface
- IMG_W, 64: pixels per row; minimum 3.
- IMG_H, 64: rows per frame; minimum 3.
- PIX_W, 8: bits per input and output pixel.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a pixel.
- in_ready  out  1  block can accept a pixel this cycle.
- in_data  in  PIX_W  unsigned pixel, raster order (row 0 col 0 first).
- mode  in  1  0 = binary edge map, 1 = magnitude.
- threshold  in  PIX_W+4  unsigned edge threshold for mode 0.
- out_valid  out  1  out_data and out_last are valid.
- out_ready  in  1  sink accepts the result this cycle.
- out_data  out  PIX_W  result pixel.
- out_last  out  1  marks the final result of a frame.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Input position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each input transfer.
  - col wraps to 0 and increments row.
  - After (IMG_H-1, IMG_W-1), both counters wrap to (0, 0) and the next frame begins.
- Line buffers:
  - Two line buffers of IMG_W x PIX_W hold rows r-1 and r-2.
  - They are read asynchronously at address col.
  - On each input transfer, the column {lb2[col], lb1[col], in_data} shifts into a 3x3 window register.
  - lb2[col] <= lb1[col] and lb1[col] <= in_data on the same transfer.
- Emission: an input transfer at (r, c) with r>=2 and c>=2 produces a result for centre (r-1, c-1). All other transfers produce no output, so border pixels are never emitted.
  - Each frame yields (IMG_W-2)*(IMG_H-2) results.
- Window naming: p0..p8 in row-major order, p0 = top-left, p4 = centre.
- Arithmetic is exact, with no pre-shift of inputs:
  - Gx = (p2 + 2p5 + p8) - (p0 + 2p3 + p6)
  - Gy = (p6 + 2p7 + p8) - (p0 + 2p1 + p2)
  - Both are signed PIX_W+4 bits.
  - mag = |Gx| + |Gy|, unsigned PIX_W+4 bits, maximum 8*(2^PIX_W-1), no overflow.
- Result encoding:
  - mode 0: out_data = all ones if mag > threshold (strict), else 0.
  - mode 1: out_data = mag saturated to 2^PIX_W-1.
- mode and threshold are latched on the first input transfer of each frame (row 0, col 0) and held for the whole frame. Changes mid-frame take effect at the next frame.
- out_last = 1 on the result for centre (IMG_H-2, IMG_W-2).
- Reset (asserted at any time, including mid-frame):
  - Counters go to (0, 0) and the partial frame is discarded.
  - out_valid = 0, out_data = 0, out_last = 0.
  - Latched mode = 0, latched threshold = 0.
  - Line buffer and window contents are not reset; they are never used before being refilled.

## Timing
- Single output register stage. in_ready = !out_valid || out_ready, so there is no combinational path from in_valid to in_ready.
- Latency: a result appears, out_valid = 1, on the cycle after the qualifying input transfer.
- Throughput: one pixel per cycle when out_ready is held at 1.
- Output hold: while out_valid && !out_ready, out_data and out_last hold stable, in_ready = 0, and no counter or buffer advances.
- Simultaneous output transfer and qualifying input transfer: the register reloads with the new result and out_valid stays 1.
- Output transfer with a non-qualifying input transfer: out_valid drops to 0 on the next cycle.
- Frame boundary: the first pixel of frame N+1 may be accepted on the cycle immediately after the last pixel of frame N, with no bubble.
- in_ready = 1 on the first cycle after reset deassertion.

## Test plan
- Flat frame, all pixels 100, IMG 64x64, PIX_W 8, mode 0, threshold 27: exactly 3844 results, all 0; out_last only on the 3844th.
- Vertical step (cols 0..31 = 0, cols 32..63 = 255), mode 0, threshold 27: results are 255 at centre cols 31 and 32 and 0 elsewhere. Repeat in mode 1: same columns read 255 (saturated from mag 1020).
- Horizontal ramp (pixel = col), mode 1: every result is 8. Mode 0 with threshold 8 gives all 0; threshold 7 gives all 255.
- Random out_ready (50%) with random in_valid gaps on the step image: the output sequence is identical to the no-stall run, and out_data never changes while out_valid && !out_ready.
- Assert reset after 1000 accepted pixels, then stream a fresh flat frame: out_valid = 0 during reset, then exactly 3844 all-zero results.
- Change mode from 0 to 1 at pixel 2000 of a step frame: the whole frame is binary; the next frame is magnitude.
